// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO and launch controller feeding the UART transmitter
// Optional sticky overflow flag built when UART_TXF_OVF_FLAG_EN is defined.
module uart_tx_fifo #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DBIT-1:0]   wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              tx_start,
    output logic [DBIT-1:0]   tx_data,
    input  logic              tx_done_tick,
    output logic              ovf
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wp_q, wp_d;
    logic [ADDR_W-1:0]   rp_q, rp_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                tx_start_q, tx_start_d;
    logic [DBIT-1:0]     tx_data_q, tx_data_d;
    logic [DBIT-1:0]     mem_q [DEPTH];
    logic                push, pop;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

    // full/empty come from the registered count, so a write while full is
    // rejected even when a pop happens on the same edge.
    assign push = wr_en && !full;
    assign pop  = (state_q == S_IDLE) && !empty;

    always_comb begin
        state_d    = state_q;
        wp_d       = wp_q;
        rp_d       = rp_q;
        count_d    = count_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;

        if (push) begin
            wp_d = wp_q + ADDR_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    tx_data_d  = mem_q[rp_q];
                    rp_d       = rp_q + ADDR_W'(1);
                    tx_start_d = 1'b1;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tx_done_tick) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Storage array carries no reset; stale entries are never read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wp_q] <= wr_data;
        end
    end

`ifdef UART_TXF_OVF_FLAG_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q | (wr_en & full);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule
